// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
//   Shared types and encodings for the data-memory port.
//   - lsq         : one store-queue entry as committed to data memory
//                   (byte address, store data, word/halfword select).
//   - LOAD_OPCODE : RISC-V LOAD major opcode driven toward the memory.
//   - FUNCT3_*    : load width encodings understood by the data memory.
// -----------------------------------------------------------------------------
package types_pkg;

    localparam logic [6:0] LOAD_OPCODE = 7'b0000011;
    localparam logic [2:0] FUNCT3_LBU  = 3'b100;
    localparam logic [2:0] FUNCT3_LW   = 3'b010;

    // sw_sh_signal: 1 = full word store, 0 = halfword store
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ps2_data;
        logic        sw_sh_signal;
    } lsq;

endpackage

// File: rtl/load_tag_pipe.sv
// -----------------------------------------------------------------------------
// load_tag_pipe
//   Two-stage shadow of the fixed-latency data memory. Each stage carries
//   (valid, live, tag) for a load issued one and two cycles ago.
//   "valid" mirrors what the memory will return and is never killed, so the
//   protocol check stays exact across a flush; "live" says whether the
//   response is still wanted on the CDB.
//
//   Ports
//     clk, reset : clock, synchronous active-high reset
//     push       : a load was issued this cycle
//     tag        : destination tag of the issued load
//     kill       : drop the live bit of every in-flight load at the next edge
//     s1_valid   : a load occupies stage 1
//     s2_valid   : a load occupies stage 2 (memory data due this cycle)
//     s2_live    : the stage 2 load has not been flushed
//     s2_tag     : destination tag of the stage 2 load
// -----------------------------------------------------------------------------
module load_tag_pipe
    import types_pkg::*;
#(
    parameter int TAG_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [TAG_W-1:0] tag,
    input  logic             kill,
    output logic             s1_valid,
    output logic             s2_valid,
    output logic             s2_live,
    output logic [TAG_W-1:0] s2_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_live_q,  s1_live_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic             s2_live_q,  s2_live_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    always_comb begin
        s1_valid_d = push;
        s1_live_d  = push && !kill;
        s1_tag_d   = tag;

        s2_valid_d = s1_valid_q;
        s2_live_d  = s1_live_q && !kill;
        s2_tag_d   = s1_tag_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_live_q  <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_live_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_live_q  <= s1_live_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_live_q  <= s2_live_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign s1_valid = s1_valid_q;
    assign s2_valid = s2_valid_q;
    assign s2_live  = s2_live_q;
    assign s2_tag   = s2_tag_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one data-memory port between loads from the memory FU and store
//   commits from the LSQ head. Stores win by default; a load that has been
//   held off for STARVE_LIMIT cycles takes priority. Loads have a fixed
//   two-cycle memory latency and are tracked by load_tag_pipe so the return
//   data can be tagged for the CDB, or discarded after a flush.
//
//   Ports
//     clk, reset                       : clock, synchronous active-high reset
//     ld_valid/ld_ready                : load request handshake
//     ld_addr/ld_func3/ld_tag          : load address, width, destination tag
//     st_valid/st_ready, st_entry      : store commit handshake and entry
//     flush                            : mispredict recovery
//     mem_issued/mem_addr/mem_opcode/
//     mem_func3                        : load-side memory drive
//     mem_store_wb/mem_lsq             : store-side memory drive
//     mem_data/mem_valid               : memory return
//     rsp_valid/rsp_data/rsp_tag       : load writeback to CDB
//     busy                             : loads in flight
//     proto_err                        : sticky, memory return out of step
// -----------------------------------------------------------------------------
module dmem_port_arbiter
    import types_pkg::*;
#(
    parameter int TAG_W        = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_func3,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_valid,
    output logic             st_ready,
    input  lsq               st_entry,
    input  logic             flush,
    output logic             mem_issued,
    output logic [31:0]      mem_addr,
    output logic [6:0]       mem_opcode,
    output logic [2:0]       mem_func3,
    output logic             mem_store_wb,
    output lsq               mem_lsq,
    input  logic [31:0]      mem_data,
    input  logic             mem_valid,
    output logic             rsp_valid,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             proto_err
);

    localparam int              CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             proto_err_q,  proto_err_d;
    logic             starve_hit;
    logic             ld_fire;
    logic             st_fire;
    logic             s1_valid;
    logic             s2_valid;
    logic             s2_live;
    logic [TAG_W-1:0] s2_tag;

    // Arbitration. A starved load blocks stores; otherwise stores go first.
    // Flush only gates loads, so the LSQ can keep draining committed stores.
    always_comb begin
        starve_hit = (starve_cnt_q == LIMIT);
        ld_ready   = !flush && (!st_valid || starve_hit);
        st_ready   = !(ld_valid && !flush && starve_hit);
        ld_fire    = ld_valid && ld_ready;
        st_fire    = st_valid && st_ready;
    end

    // Starvation counter: counts consecutive cycles a live load request is
    // held off, and saturates so the load keeps priority until it fires.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ld_fire || !ld_valid || flush) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Memory should return data exactly when stage 2 holds a load (flushed
    // or not); any disagreement is latched until reset.
    always_comb begin
        proto_err_d = proto_err_q || (mem_valid != s2_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    load_tag_pipe #(
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .push     (ld_fire),
        .tag      (ld_tag),
        .kill     (flush),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid),
        .s2_live  (s2_live),
        .s2_tag   (s2_tag)
    );

    always_comb begin
        mem_issued   = ld_fire;
        mem_addr     = ld_addr;
        mem_func3    = ld_func3;
        mem_opcode   = ld_fire ? LOAD_OPCODE : 7'b0;
        mem_store_wb = st_fire;
        mem_lsq      = st_entry;

        // Flush acts on the pipe from the next edge, so data returning in
        // the flush cycle itself is still delivered.
        rsp_valid    = mem_valid && s2_valid && s2_live;
        rsp_data     = mem_data;
        rsp_tag      = s2_tag;

        busy         = s1_valid || s2_valid;
        proto_err    = proto_err_q;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  import types_pkg::*;

  localparam int TAG_W = 7;
  localparam int LIMIT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             ld_valid;
  logic             ld_ready;
  logic [31:0]      ld_addr;
  logic [2:0]       ld_func3;
  logic [TAG_W-1:0] ld_tag;
  logic             st_valid;
  logic             st_ready;
  lsq               st_entry;
  logic             flush;
  logic             mem_issued;
  logic [31:0]      mem_addr;
  logic [6:0]       mem_opcode;
  logic [2:0]       mem_func3;
  logic             mem_store_wb;
  lsq               mem_lsq;
  logic [31:0]      mem_data;
  logic             mem_valid;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic             proto_err;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .TAG_W        (TAG_W),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_addr      (ld_addr),
    .ld_func3     (ld_func3),
    .ld_tag       (ld_tag),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_entry     (st_entry),
    .flush        (flush),
    .mem_issued   (mem_issued),
    .mem_addr     (mem_addr),
    .mem_opcode   (mem_opcode),
    .mem_func3    (mem_func3),
    .mem_store_wb (mem_store_wb),
    .mem_lsq      (mem_lsq),
    .mem_data     (mem_data),
    .mem_valid    (mem_valid),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  // Data memory helpers: lw returns the word, lbu the zero-extended byte;
  // sw writes the word, sh the halfword selected by addr[1].
  function automatic logic [31:0] rd_word(input bit [31:0] w, input logic [31:0] a,
                                          input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {a[1:0], 3'b000};
    if (f3 == FUNCT3_LBU) return {24'b0, s[7:0]};
    return w;
  endfunction

  function automatic bit [31:0] wr_word(input bit [31:0] w, input lsq e);
    bit [31:0] r;
    r = w;
    if (e.sw_sh_signal) r = e.ps2_data;
    else if (e.addr[1]) r[31:16] = e.ps2_data[15:0];
    else r[15:0] = e.ps2_data[15:0];
    return r;
  endfunction

  // Behavioural data memory: fixed two-cycle load latency, held in reset
  // together with the DUT. mem_force injects a spurious return.
  bit [31:0] mem [64];
  bit        mp1_v, mp2_v;
  bit [31:0] mp1_d, mp2_d;
  logic      mem_force;

  assign mem_valid = mp2_v | mem_force;
  assign mem_data  = mp2_d;

  always @(posedge clk) begin
    if (reset) begin
      mp1_v <= 1'b0;
      mp2_v <= 1'b0;
    end else begin
      mp1_v <= mem_issued;
      mp1_d <= rd_word(mem[mem_addr[7:2]], mem_addr, mem_func3);
      mp2_v <= mp1_v;
      mp2_d <= mp1_d;
    end
    if (mem_store_wb) mem[mem_lsq.addr[7:2]] <= wr_word(mem[mem_lsq.addr[7:2]], mem_lsq);
  end

  // Reference model: outstanding loads by issue cycle, a blocked-cycle count,
  // a sticky error flag and a shadow copy of memory contents.
  typedef struct {
    int               fc;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    bit               live;
  } ent_t;

  ent_t      q[$];
  int        cyc;
  int        blk;
  bit        exp_proto;
  bit [31:0] rmem [64];
  bit        chk_en;
  int        n_total, n_pass, n_fail;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit               hit, e_ldr, e_str, e_lf, e_sf, e_rv, e_busy, e_mv, due;
    logic [TAG_W-1:0] e_tag;
    logic [31:0]      e_data;
    @(negedge clk);
    hit    = (blk == LIMIT);
    e_ldr  = !flush && (!st_valid || hit);
    e_str  = !(ld_valid && !flush && hit);
    e_lf   = ld_valid && e_ldr;
    e_sf   = st_valid && e_str;
    e_rv   = 1'b0;
    e_busy = 1'b0;
    due    = 1'b0;
    e_tag  = '0;
    e_data = '0;
    foreach (q[i]) begin
      if (q[i].fc == cyc - 1) e_busy = 1'b1;
      if (q[i].fc == cyc - 2) begin
        e_busy = 1'b1;
        due    = 1'b1;
        if (q[i].live) begin
          e_rv   = 1'b1;
          e_tag  = q[i].tag;
          e_data = q[i].data;
        end
      end
    end
    e_mv = due || mem_force;
    if (chk_en) begin
      chk("ld_ready",     96'(ld_ready),     96'(e_ldr));
      chk("st_ready",     96'(st_ready),     96'(e_str));
      chk("mem_issued",   96'(mem_issued),   96'(e_lf));
      chk("mem_opcode",   96'(mem_opcode),   96'(e_lf ? 7'b0000011 : 7'b0));
      chk("mem_addr",     96'(mem_addr),     96'(ld_addr));
      chk("mem_func3",    96'(mem_func3),    96'(ld_func3));
      chk("mem_store_wb", 96'(mem_store_wb), 96'(e_sf));
      chk("mem_lsq_addr", 96'(mem_lsq.addr), 96'(st_entry.addr));
      chk("mem_lsq_data", 96'(mem_lsq.ps2_data), 96'(st_entry.ps2_data));
      chk("rsp_valid",    96'(rsp_valid),    96'(e_rv));
      if (e_rv) begin
        chk("rsp_tag",  96'(rsp_tag),  96'(e_tag));
        chk("rsp_data", 96'(rsp_data), 96'(e_data));
      end
      chk("busy",      96'(busy),      96'(e_busy));
      chk("proto_err", 96'(proto_err), 96'(exp_proto));
    end
    @(posedge clk);
    if (e_sf) rmem[st_entry.addr[7:2]] = wr_word(rmem[st_entry.addr[7:2]], st_entry);
    if (reset) begin
      q.delete();
      blk       = 0;
      exp_proto = 1'b0;
    end else begin
      if (e_mv != due) exp_proto = 1'b1;
      while (q.size() > 0 && q[0].fc <= cyc - 2) void'(q.pop_front());
      if (flush) foreach (q[i]) if (q[i].fc == cyc - 1) q[i].live = 1'b0;
      if (e_lf) q.push_back('{cyc, ld_tag, rd_word(rmem[ld_addr[7:2]], ld_addr, ld_func3), 1'b1});
      if (e_lf || !ld_valid || flush) blk = 0;
      else if (blk < LIMIT) blk++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    ld_valid = 1'b0; st_valid = 1'b0; flush = 1'b0; mem_force = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3, input logic [TAG_W-1:0] t);
    ld_valid = 1'b1; ld_addr = a; ld_func3 = f3; ld_tag = t;
  endtask

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_func3 = FUNCT3_LW; ld_tag = '0;
    st_valid = 1'b0; st_entry = '0; flush = 1'b0; mem_force = 1'b0;
    cyc = 0; blk = 0; exp_proto = 1'b0; chk_en = 1'b0;
    n_total = 0; n_pass = 0; n_fail = 0;
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    idle(2);

    // Seed memory, then a lone load (tag 5 at 0x40)
    st_valid = 1'b1; st_entry = '{32'h40, 32'hDEADBEEF, 1'b1};
    step();
    st_valid = 1'b0;
    load(32'h40, FUNCT3_LW, 7'd5);
    step();
    idle(3);

    // Contention: store and load both held for 6 cycles
    st_valid = 1'b1;
    load(32'h41, FUNCT3_LBU, 7'd11);
    for (int i = 0; i < 6; i++) begin
      st_entry = '{32'h80 + 32'(4 * i), $urandom, 1'b1};
      step();
    end
    idle(3);

    // Back-to-back loads, tags 1,2,3
    for (int i = 1; i <= 3; i++) begin
      load(32'h40, FUNCT3_LW, 7'(i));
      step();
    end
    idle(3);

    // Flush after a load: response suppressed, stores still accepted
    load(32'h80, FUNCT3_LW, 7'd9);
    step();
    ld_valid = 1'b0; flush = 1'b1; st_valid = 1'b1;
    st_entry = '{32'hC2, 32'h0000_BEEF, 1'b0};
    step();
    idle(3);

    // Spurious memory return with an empty pipe
    mem_force = 1'b1;
    step();
    idle(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle(2);

    // Reset the cycle after a load issues
    load(32'h40, FUNCT3_LW, 7'd20);
    step();
    ld_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_addr  = $urandom & 32'hFF;
      ld_func3 = $urandom_range(0, 1) ? FUNCT3_LBU : FUNCT3_LW;
      ld_tag   = 7'($urandom);
      st_valid = $urandom_range(0, 1) == 1;
      st_entry = '{$urandom & 32'hFF, $urandom, 1'($urandom)};
      flush    = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 The block SHALL take parameter TAG_W, default 7, as the load destination-tag width (physical register index).
REQ-002 The block SHALL take parameter STARVE_LIMIT, default 4, as the number of blocked cycles after which a waiting load wins over stores.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ld_valid / ld_ready  in / out  1 / 1  load request handshake from the memory FU.
REQ-006 ld_addr / ld_func3 / ld_tag  in  32 / 3 / TAG_W  load byte address, func3 (lbu=100, lw=010), destination tag.
REQ-007 st_valid / st_ready  in / out  1 / 1  store-commit handshake from the LSQ head.
REQ-008 st_entry  in  lsq  LSQ entry to commit (addr, ps2_data, sw_sh_signal).
REQ-009 flush  in  1  mispredict recovery; kills in-flight load responses.
REQ-010 mem_issued / mem_addr / mem_opcode / mem_func3  out  1 / 32 / 7 / 3  load-side drive of the data memory.
REQ-011 mem_store_wb / mem_lsq  out  1 / lsq  store-side drive of the data memory.
REQ-012 mem_data / mem_valid  in  32 / 1  data memory return.
REQ-013 rsp_valid / rsp_data / rsp_tag  out  1 / 32 / TAG_W  load writeback to CDB.
REQ-014 busy / proto_err  out  1 / 1  loads in flight; sticky protocol-error flag.

Function
REQ-015 A transfer SHALL occur on a cycle where valid and ready are both high (ld_fire, st_fire); at most one of ld_fire, st_fire SHALL be high per cycle.
REQ-016 starve_hit SHALL equal (starve_cnt == STARVE_LIMIT).
REQ-017 ld_ready SHALL equal !flush && (!st_valid || starve_hit).
REQ-018 st_ready SHALL equal !(ld_valid && !flush && starve_hit); stores are never blocked by flush.
REQ-019 starve_cnt SHALL increment, saturating at STARVE_LIMIT, each cycle ld_valid && !ld_fire && !flush, and SHALL clear on ld_fire, on !ld_valid, or on flush.
REQ-020 mem_issued SHALL equal ld_fire combinationally; mem_opcode SHALL be 7'b0000011 when ld_fire, else 7'b0; mem_addr/mem_func3 SHALL pass ld_addr/ld_func3.
REQ-021 mem_store_wb SHALL equal st_fire combinationally; mem_lsq SHALL pass st_entry.
REQ-022 Load latency is fixed: a load fired in cycle T SHALL see mem_valid in cycle T+2.
REQ-023 A two-stage tag pipe SHALL hold (valid, live, tag) per stage: stage1 loads {ld_fire, ld_fire, ld_tag} each cycle; stage2 loads stage1.
REQ-024 On flush, the live bits of both stages SHALL clear at the next edge; valid bits SHALL be unaffected.
REQ-025 rsp_valid SHALL equal mem_valid && s2_valid && s2_live (combinational); rsp_data = mem_data; rsp_tag = s2_tag.
REQ-026 A response arriving in the flush cycle itself SHALL still be delivered (flush affects stages only from the next edge).
REQ-027 proto_err SHALL set when mem_valid != s2_valid and SHALL stay set until reset.
REQ-028 busy SHALL equal s1_valid || s2_valid.
REQ-029 Back-to-back loads SHALL be accepted every cycle (throughput 1/cycle); no outstanding limit beyond the pipe.

Reset
REQ-030 On reset, starve_cnt, all stage valid/live/tag bits and proto_err SHALL clear to 0 at the next edge.
REQ-031 After reset: rsp_valid=0, busy=0, proto_err=0, mem_issued=0, mem_store_wb=0; ld_ready/st_ready follow REQ-017/018 from zero state.
REQ-032 Reset mid-operation SHALL drop all in-flight responses; the bench SHALL hold data memory in reset concurrently.

Structure
REQ-033 The lsq struct, LOAD_OPCODE (7'b0000011) and FUNCT3_LBU/FUNCT3_LW constants SHALL come from types_pkg.
REQ-034 The tag pipe SHALL be a sub-module named load_tag_pipe (parameter TAG_W, inputs push/tag/kill, outputs s2 fields).

Verification
REQ-035 Load alone: ld_valid=1, addr=0x40, func3=010, tag=5, st_valid=0 -> mem_issued=1 cycle T; rsp_valid=1, rsp_tag=5 in T+2.
REQ-036 Contention: st_valid and ld_valid held 1 for 6 cycles -> stores fire cycles 0-3, load fires cycle 4 (STARVE_LIMIT=4), starve_cnt returns to 0.
REQ-037 Back-to-back: loads tags 1,2,3 in consecutive cycles -> rsp_tag 1,2,3 in consecutive cycles two later, busy high throughout.
REQ-038 Flush: load tag 9 fired in T, flush in T+1 -> no rsp_valid in T+2, proto_err stays 0; st_ready stays 1 during flush.
REQ-039 Protocol: force mem_valid=1 with empty pipe -> proto_err=1 next cycle, held until reset.
REQ-040 Mid-flight reset: load fired T, reset in T+1 -> rsp_valid=0, busy=0 from T+2.
